// File: rtl/lsu_if.sv
// lsu_if: core request/response and memory bus signals of the load/store unit.
// slave is the lsu side; master is the core plus memory side that drives it.
interface lsu_if;
  logic        req_valid;
  logic        req_ready;
  logic        rd_mem_en;
  logic        wr_mem_en;
  logic [3:0]  wr_rd_mem_len;
  logic [6:0]  rd_mem_op;
  logic [63:0] addr;
  logic [63:0] wdata;

  logic        resp_valid;
  logic [63:0] rdata;
  logic        misalign_err;

  logic        mem_req;
  logic        mem_we;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [7:0]  mem_wstrb;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [63:0] mem_rdata;

  modport slave (
    input  req_valid, rd_mem_en, wr_mem_en, wr_rd_mem_len, rd_mem_op, addr, wdata,
    output req_ready, resp_valid, rdata, misalign_err,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    input  mem_gnt, mem_rvalid, mem_rdata
  );

  modport master (
    output req_valid, rd_mem_en, wr_mem_en, wr_rd_mem_len, rd_mem_op, addr, wdata,
    input  req_ready, resp_valid, rdata, misalign_err,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    output mem_gnt, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/lsu.sv
// lsu: one outstanding load/store; resp at N+2 (store, or load with gnt+rvalid together), N+3+ otherwise; req_ready low while busy, bus held until mem_gnt.
// Defining LSU_MISALIGN_CHECK_EN faults misaligned or bad-length requests straight to a response with no bus access.
module lsu (
  input logic  clk,
  input logic  rst,
  lsu_if.slave bus
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

  state_t      state_q, state_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [63:0] mem_addr_q, mem_addr_d;
  logic [63:0] mem_wdata_q, mem_wdata_d;
  logic [7:0]  mem_wstrb_q, mem_wstrb_d;
  logic        resp_valid_q, resp_valid_d;
  logic [63:0] rdata_q, rdata_d;
  logic [2:0]  off_q, off_d;
  logic [6:0]  op_q, op_d;

  logic        is_store;
  logic        is_load;
  logic        accept;
  logic        misalign_hit;
  logic [7:0]  len_mask;
  logic [15:0] strb_wide;
  logic [63:0] load_shift;

  // Op bits, MSB first: lbu, lhu, lwu, lb, lh, lw, ld; no bit set means ld.
  function automatic logic [63:0] load_ext(input logic [6:0] op, input logic [63:0] s);
    logic [63:0] r;
    if (op[6])      r = {56'd0, s[7:0]};
    else if (op[5]) r = {48'd0, s[15:0]};
    else if (op[4]) r = {32'd0, s[31:0]};
    else if (op[3]) r = {{56{s[7]}}, s[7:0]};
    else if (op[2]) r = {{48{s[15]}}, s[15:0]};
    else if (op[1]) r = {{32{s[31]}}, s[31:0]};
    else            r = s;
    return r;
  endfunction

  always_comb begin
    is_store = bus.wr_mem_en;
    is_load  = bus.rd_mem_en | (|bus.rd_mem_op);
    accept   = bus.req_valid & (is_store | is_load);
    case (bus.wr_rd_mem_len)
      4'd1:    len_mask = 8'h01;
      4'd2:    len_mask = 8'h03;
      4'd4:    len_mask = 8'h0F;
      default: len_mask = 8'hFF;
    endcase
    // Lanes shifted past byte 7 fall off the top; there is no second access.
    strb_wide  = {8'h00, len_mask} << bus.addr[2:0];
    load_shift = bus.mem_rdata >> {off_q, 3'b000};
  end

`ifdef LSU_MISALIGN_CHECK_EN
  logic       len_ok;
  logic [2:0] len_m1;
  logic       misalign_q, misalign_d;

  always_comb begin
    len_ok = (bus.wr_rd_mem_len == 4'd1) || (bus.wr_rd_mem_len == 4'd2) ||
             (bus.wr_rd_mem_len == 4'd4) || (bus.wr_rd_mem_len == 4'd8);
    len_m1 = bus.wr_rd_mem_len[2:0] - 3'd1;
    misalign_hit = !len_ok || ((bus.addr[2:0] & len_m1) != 3'd0);
  end

  assign bus.misalign_err = misalign_q;
`else
  assign misalign_hit     = 1'b0;
  assign bus.misalign_err = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_wstrb_d  = mem_wstrb_q;
    resp_valid_d = 1'b0;
    rdata_d      = rdata_q;
    off_d        = off_q;
    op_d         = op_q;
`ifdef LSU_MISALIGN_CHECK_EN
    misalign_d   = misalign_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          off_d       = bus.addr[2:0];
          op_d        = bus.rd_mem_op;
          mem_we_d    = is_store;
          mem_addr_d  = {bus.addr[63:3], 3'b000};
          mem_wdata_d = bus.wdata << {bus.addr[2:0], 3'b000};
          mem_wstrb_d = strb_wide[7:0];
          rdata_d     = 64'd0;
`ifdef LSU_MISALIGN_CHECK_EN
          misalign_d  = misalign_hit;
`endif
          if (misalign_hit) begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
          end else begin
            state_d   = REQ;
            mem_req_d = 1'b1;
          end
        end
      end
      REQ: begin
        if (bus.mem_gnt) begin
          mem_req_d = 1'b0;
          if (mem_we_q) begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
          end else if (bus.mem_rvalid) begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
            rdata_d      = load_ext(op_q, load_shift);
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (bus.mem_rvalid) begin
          state_d      = RESP;
          resp_valid_d = 1'b1;
          rdata_d      = load_ext(op_q, load_shift);
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= 64'd0;
      mem_wdata_q  <= 64'd0;
      mem_wstrb_q  <= 8'd0;
      resp_valid_q <= 1'b0;
      rdata_q      <= 64'd0;
      off_q        <= 3'd0;
      op_q         <= 7'd0;
`ifdef LSU_MISALIGN_CHECK_EN
      misalign_q   <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_wstrb_q  <= mem_wstrb_d;
      resp_valid_q <= resp_valid_d;
      rdata_q      <= rdata_d;
      off_q        <= off_d;
      op_q         <= op_d;
`ifdef LSU_MISALIGN_CHECK_EN
      misalign_q   <= misalign_d;
`endif
    end
  end

  assign bus.req_ready  = (state_q == IDLE);
  assign bus.resp_valid = resp_valid_q;
  assign bus.rdata      = rdata_q;
  assign bus.mem_req    = mem_req_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.mem_wstrb  = mem_wstrb_q;
endmodule
